// File: rtl/rom_reader_multichannel.sv
// Reads words from a bank of parallel ROM sockets: single reads stepped by buttons, or a full scan.
// Define ROM_READER_DEBOUNCE_EN to add a per-button debounce filter after the synchronizers.
module rom_reader_multichannel #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDRESS_WIDTH   = 9,
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CH_W-1:0]          channel_select,
  input  logic                     increment_address,
  input  logic                     decrement_address,
  input  logic                     scan_start,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic [CHANNELS-1:0]      chip_selection,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     channel_error
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || CHANNELS < 1) begin : g_bad_params
    $error("rom_reader_multichannel: SETTLE_CYCLES, DEBOUNCE_CYCLES and CHANNELS must be >= 1");
  end

  // Button bit order: {scan_start, decrement_address, increment_address}
  logic [2:0] btn_sync1_q, btn_sync2_q, btn_level, btn_prev_q, btn_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      btn_prev_q  <= '0;
    end else begin
      btn_sync1_q <= {scan_start, decrement_address, increment_address};
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_level;
    end
  end

`ifdef ROM_READER_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

  logic [2:0]      db_cand_q, db_level_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  // Run length of identical synchronized samples, saturating once the level is accepted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (btn_sync2_q[i] != db_cand_q[i]) begin
        db_cnt_d[i] = DB_W'(1);
      end else if (db_cnt_q[i] != DB_FULL) begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end else begin
        db_cnt_d[i] = db_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_cand_q  <= '0;
      db_level_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= DB_FULL;
    end else begin
      db_cand_q <= btn_sync2_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        if (db_cnt_d[i] == DB_FULL) db_level_q[i] <= btn_sync2_q[i];
      end
    end
  end

  assign btn_level = db_level_q;
`else
  assign btn_level = btn_sync2_q;
`endif

  assign btn_rise = btn_level & ~btn_prev_q;

  logic scan_ev, step_up, step_down, channel_valid, start_read;

  assign channel_error = ({1'b0, channel_select} >= CH_LIMIT);
  assign channel_valid = ~channel_error;
  assign scan_ev       = btn_rise[2];
  // Simultaneous up and down cancel each other.
  assign step_up       = btn_rise[0] & ~btn_rise[1];
  assign step_down     = btn_rise[1] & ~btn_rise[0];

  typedef enum logic [1:0] {StIdle, StSelect, StCapture, StAdvance} state_e;

  state_e          state_q;
  logic            start_q, scan_q;
  logic [CH_W-1:0] chan_q;
  logic [SW-1:0]   settle_q;

  assign start_read = channel_valid & (start_q | scan_ev | step_up | step_down);

  function automatic logic [CHANNELS-1:0] select_mask(input logic [CH_W-1:0] ch);
    logic [CHANNELS-1:0] mask;
    mask     = '1;
    mask[ch] = 1'b0;
    return mask;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      start_q        <= 1'b1;
      scan_q         <= 1'b0;
      chan_q         <= '0;
      settle_q       <= '0;
      chip_address   <= '0;
      chip_selection <= '1;
      data_out       <= '0;
      data_valid     <= 1'b0;
      busy           <= 1'b0;
      scan_done      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      scan_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The first cycle out of reset reads address 0 and ignores buttons.
          start_q <= 1'b0;
          if (start_q || scan_ev) begin
            chip_address <= '0;
          end else if (step_up) begin
            chip_address <= chip_address + ADDR_ONE;
          end else if (step_down) begin
            chip_address <= chip_address - ADDR_ONE;
          end
          if (start_read) begin
            state_q        <= StSelect;
            scan_q         <= scan_ev & ~start_q;
            chan_q         <= channel_select;
            chip_selection <= select_mask(channel_select);
            settle_q       <= '0;
            busy           <= 1'b1;
          end
        end
        StSelect: begin
          if (settle_q == SETTLE_LAST) begin
            data_out       <= chip_data_in;
            data_valid     <= 1'b1;
            chip_selection <= '1;
            state_q        <= StCapture;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        StCapture: begin
          if (scan_q && chip_address != ADDR_MAX) begin
            state_q <= StAdvance;
          end else begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            scan_done <= scan_q;
            scan_q    <= 1'b0;
          end
        end
        StAdvance: begin
          chip_address   <= chip_address + ADDR_ONE;
          chip_selection <= select_mask(chan_q);
          settle_q       <= '0;
          state_q        <= StSelect;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader_multichannel.sv
// Self-checking bench for rom_reader_multichannel: directed table, random button model, scan, resets.
module tb_rom_reader_multichannel;

  localparam int SETTLE = 4;
`ifdef ROM_READER_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 3;
`endif

  typedef struct {
    logic       inc;
    logic       dec;
    logic       ch;
    logic [8:0] exp_addr;
    int         exp_reads;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:0] channel_select;
  logic       increment_address, decrement_address, scan_start;
  logic [7:0] chip_data_in, data_out;
  logic [8:0] chip_address;
  logic [1:0] chip_selection;
  logic       data_valid, busy, scan_done, channel_error;

  logic [1:0] channel_select3;
  logic [7:0] chip_data_in3, data_out3;
  logic [8:0] chip_address3;
  logic [2:0] chip_selection3;
  logic       data_valid3, busy3, scan_done3, channel_error3;

  always #5 clk = ~clk;

  rom_reader_multichannel dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .channel_select    (channel_select),
    .increment_address (increment_address),
    .decrement_address (decrement_address),
    .scan_start        (scan_start),
    .chip_data_in      (chip_data_in),
    .chip_address      (chip_address),
    .chip_selection    (chip_selection),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .busy              (busy),
    .scan_done         (scan_done),
    .channel_error     (channel_error)
  );

  rom_reader_multichannel #(.CHANNELS(3)) dut3 (
    .clk               (clk),
    .reset_n           (reset_n),
    .channel_select    (channel_select3),
    .increment_address (increment_address),
    .decrement_address (decrement_address),
    .scan_start        (scan_start),
    .chip_data_in      (chip_data_in3),
    .chip_address      (chip_address3),
    .chip_selection    (chip_selection3),
    .data_out          (data_out3),
    .data_valid        (data_valid3),
    .busy              (busy3),
    .scan_done         (scan_done3),
    .channel_error     (channel_error3)
  );

  function automatic logic [7:0] rom_word(input int ch, input int addr);
    int v;
    v = addr * 7 + ch * 51;
    return 8'(v) ^ 8'hA5;
  endfunction

  // ROM sockets: only the selected chip drives the bus.
  always_comb begin
    chip_data_in = 8'h00;
    if (chip_selection == 2'b10) chip_data_in = rom_word(0, int'(chip_address));
    else if (chip_selection == 2'b01) chip_data_in = rom_word(1, int'(chip_address));
  end
  assign chip_data_in3 = (chip_selection3 == 3'b011) ? 8'h5A : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         cyc = 0;
  int         dv_cnt = 0, sd_cnt = 0, dv3_cnt = 0;
  int         run_len = 0, last_run = 0, last_dv_cyc = 0, sd_cyc = 0;
  logic [1:0] last_mask = 2'b11;
  logic [2:0] last_mask3 = 3'b111;
  bit         sel3_low_seen = 1'b0;
  logic [8:0] dv_addr_q[$];
  logic [1:0] dv_mask_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe every read: select window length and captured word against the ROM model.
  always @(negedge clk) begin
    if (!reset_n) begin
      run_len = 0;
    end else begin
      if (chip_selection != 2'b11) begin
        run_len++;
        last_mask = chip_selection;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (data_valid) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        dv_addr_q.push_back(chip_address);
        dv_mask_q.push_back(last_mask);
        check("settle_len", last_run, SETTLE);
        check("capture_data", data_out, rom_word((last_mask == 2'b01) ? 1 : 0, int'(chip_address)));
        last_run = 0;
      end
      if (scan_done) begin
        sd_cnt++;
        sd_cyc = cyc;
      end
      if (chip_selection3 != 3'b111) begin
        sel3_low_seen = 1'b1;
        last_mask3    = chip_selection3;
      end
      if (data_valid3) dv3_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic inc, input logic dec, input logic scn);
    increment_address = inc;
    decrement_address = dec;
    scan_start        = scn;
    repeat (HOLD) tick();
    increment_address = 1'b0;
    decrement_address = 1'b0;
    scan_start        = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic settle_window;
    repeat (20) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, chip_address, 0);
    check({tag, "_sel"}, chip_selection, 2'b11);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_scan_done"}, scan_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, low, dv0, dv_r, sd_r, sd0, mism, maddr, r, ch;
    vec_t vecs [8];

    vecs[0] = '{inc: 1'b1, dec: 1'b0, ch: 1'b0, exp_addr: 9'h001, exp_reads: 1};
    vecs[1] = '{inc: 1'b1, dec: 1'b1, ch: 1'b0, exp_addr: 9'h001, exp_reads: 0};
    vecs[2] = '{inc: 1'b0, dec: 1'b1, ch: 1'b1, exp_addr: 9'h000, exp_reads: 1};
    vecs[3] = '{inc: 1'b0, dec: 1'b1, ch: 1'b1, exp_addr: 9'h1FF, exp_reads: 1};
    vecs[4] = '{inc: 1'b1, dec: 1'b1, ch: 1'b1, exp_addr: 9'h1FF, exp_reads: 0};
    vecs[5] = '{inc: 1'b1, dec: 1'b0, ch: 1'b0, exp_addr: 9'h000, exp_reads: 1};
    vecs[6] = '{inc: 1'b0, dec: 1'b0, ch: 1'b1, exp_addr: 9'h000, exp_reads: 0};
    vecs[7] = '{inc: 1'b0, dec: 1'b1, ch: 1'b0, exp_addr: 9'h1FF, exp_reads: 1};

    reset_n           = 1'b0;
    channel_select    = 1'b0;
    channel_select3   = 2'd3;
    increment_address = 1'b0;
    decrement_address = 1'b0;
    scan_start        = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Release: automatic read of address 0 on channel 0.
    reset_n = 1'b1;
    n = 0;
    while (chip_selection == 2'b11 && n < 10) begin
      tick();
      n++;
    end
    check("boot_mask", chip_selection, 2'b10);
    check("boot_addr_sel", chip_address, 0);
    low = 0;
    while (chip_selection == 2'b10 && low < 20) begin
      low++;
      tick();
    end
    check("boot_settle", low, SETTLE);
    check("boot_valid", data_valid, 1);
    check("boot_data", data_out, 8'hA5);
    check("boot_addr", chip_address, 0);
    tick();
    check("boot_valid_pulse", data_valid, 0);
    check("boot_busy_done", busy, 0);
    check("ch3_error", channel_error3, 1);
    check("ch3_no_read", dv3_cnt, 0);
    check("ch3_sel_idle", chip_selection3, 3'b111);
    check("ch3_busy", busy3, 0);

    // Decrement wraps 0 -> max; invalid-channel instance still moves its address.
    dv0 = dv_cnt;
    press(1'b0, 1'b1, 1'b0);
    settle_window();
    check("dec_wrap_addr", chip_address, 9'h1FF);
    check("dec_wrap_reads", dv_cnt - dv0, 1);
    check("ch3_dec_addr", chip_address3, 9'h1FF);
    check("ch3_dec_no_read", dv3_cnt, 0);
    check("ch3_never_selected", sel3_low_seen, 0);
    channel_select3 = 2'd2;
    tick();
    check("ch3_error_clear", channel_error3, 0);
    dv0 = dv_cnt;
    press(1'b1, 1'b0, 1'b0);
    settle_window();
    check("inc_wrap_addr", chip_address, 0);
    check("inc_wrap_reads", dv_cnt - dv0, 1);
    check("ch3_read", dv3_cnt, 1);
    check("ch3_mask", last_mask3, 3'b011);
    check("ch3_data", data_out3, 8'h5A);
    check("ch3_addr", chip_address3, 0);
    check("ch3_scan_done", scan_done3, 0);

    for (int i = 0; i < 8; i++) begin
      channel_select = vecs[i].ch;
      dv0 = dv_cnt;
      press(vecs[i].inc, vecs[i].dec, 1'b0);
      settle_window();
      check($sformatf("vec%0d_addr", i), chip_address, vecs[i].exp_addr);
      check($sformatf("vec%0d_reads", i), dv_cnt - dv0, vecs[i].exp_reads);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vecs[i].exp_reads != 0)
        check($sformatf("vec%0d_data", i), data_out, rom_word(int'(vecs[i].ch), int'(vecs[i].exp_addr)));
    end

    maddr = 9'h1FF;
    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 3));
      ch = int'($urandom_range(0, 1));
      channel_select = 1'(ch);
      dv0 = dv_cnt;
      press(r == 0 || r == 2, r == 1 || r == 2, 1'b0);
      settle_window();
      if (r == 0) maddr = (maddr + 1) % 512;
      if (r == 1) maddr = (maddr + 511) % 512;
      check($sformatf("rnd%0d_addr", i), chip_address, maddr);
      check($sformatf("rnd%0d_reads", i), dv_cnt - dv0, (r < 2) ? 1 : 0);
      if (r < 2) check($sformatf("rnd%0d_data", i), data_out, rom_word(ch, maddr));
    end

`ifdef ROM_READER_DEBOUNCE_EN
    // Short glitches must not register; only the stable press steps once.
    dv0 = dv_cnt;
    for (int g = 0; g < 3; g++) begin
      increment_address = 1'b1;
      repeat (3) tick();
      increment_address = 1'b0;
      repeat (2) tick();
    end
    press(1'b1, 1'b0, 1'b0);
    settle_window();
    maddr = (maddr + 1) % 512;
    check("bounce_addr", chip_address, maddr);
    check("bounce_reads", dv_cnt - dv0, 1);
`endif

    // Full scan on channel 1 with button presses thrown in while busy.
    channel_select = 1'b1;
    dv0 = dv_cnt;
    sd0 = sd_cnt;
    press(1'b0, 1'b0, 1'b1);
    check("scan_busy", busy, 1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    n = 0;
    while (sd_cnt == sd0 && n < 5000) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("scan_done_count", sd_cnt - sd0, 1);
    check("scan_reads", dv_cnt - dv0, 512);
    mism = 0;
    for (int i = 0; i < 512; i++) begin
      if (dv0 + i >= dv_addr_q.size()) mism++;
      else if (dv_addr_q[dv0 + i] != 9'(i) || dv_mask_q[dv0 + i] != 2'b01) mism++;
    end
    check("scan_order_and_mask", mism, 0);
    check("scan_done_timing", sd_cyc, last_dv_cyc + 1);
    check("scan_final_addr", chip_address, 9'h1FF);
    check("scan_idle", busy, 0);

    // Reset in the middle of a SELECT window.
    channel_select    = 1'b0;
    increment_address = 1'b1;
    n = 0;
    while (chip_selection == 2'b11 && n < 60) begin
      tick();
      n++;
    end
    check("midsel_started", chip_selection, 2'b10);
    increment_address = 1'b0;
    tick();
    dv_r    = dv_cnt + (data_valid ? 1 : 0);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midsel");
    tick();
    check("midsel_no_valid", dv_cnt - dv_r, 0);
    reset_n = 1'b1;
    settle_window();
    check("midsel_restart_reads", dv_cnt - dv_r, 1);
    check("midsel_restart_addr", chip_address, 0);
    check("midsel_restart_data", data_out, 8'hA5);

    // Reset in the middle of a scan.
    channel_select = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    repeat (60) tick();
    check("midscan_busy", busy, 1);
    dv_r    = dv_cnt + (data_valid ? 1 : 0);
    sd_r    = sd_cnt + (scan_done ? 1 : 0);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midscan");
    tick();
    reset_n = 1'b1;
    settle_window();
    check("midscan_reads", dv_cnt - dv_r, 1);
    check("midscan_no_done", sd_cnt - sd_r, 0);
    check("midscan_addr", chip_address, 0);
    check("midscan_data", data_out, rom_word(1, 0));
    check("midscan_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
